// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the unified-memory arbiter.
//            State encoding, requester port indices and default widths.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester port indices; also the bit positions in the grant vector.
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_MEM_DEPTH = 16;
    localparam int DEF_RD_LAT    = 1;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Combinational two-way round-robin picker. A lone request wins
//            outright; on a tie the port that did not win last time wins.
// Ports    : i_req[1:0]    request per port (bit index = port index)
//            i_last_grant  port index of the previous winner
//            o_grant[1:0]  one-hot grant
//            o_valid       at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_valid
);

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_last_grant == PORT_LS) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    assign o_valid = |i_req;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates the instruction-fetch (IF, read-only) and load/store
//            (LS, read/write) ports onto the shared unified memory, sequences
//            the MemRead/MemWrite strobes and returns data with a 1-cycle ack.
// Ports    : CLK, reset (sync, active-high)
//            if_req/if_addr -> if_ack/if_rdata
//            ls_req/ls_we/ls_addr/ls_wdata -> ls_ack/ls_rdata
//            err (with ack, out-of-range access), busy (not IDLE)
//            MemRead/MemWrite/ADDR/Data_in -> memory, Data_out <- memory
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int RD_LAT    = DEF_RD_LAT
)(
    input  logic              CLK,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              err,
    output logic              busy,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_in,
    input  logic [DATA_W-1:0] Data_out
);

    // Read strobe down-counter reload: counts RD_LAT cycles ending at zero.
    localparam logic [2:0]        c_RD_LOAD = 3'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] c_DEPTH   = ADDR_W'(MEM_DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic              r_last_grant;
    logic              r_we;
    logic              r_oor;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;

    logic [1:0]        w_grant;
    logic              w_valid;
    logic              w_sel;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_oor;

    rr_arb2 u_rr_arb2 (
        .i_req        ({ls_req, if_req}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_valid      (w_valid)
    );

    assign w_sel      = w_grant[PORT_LS];
    assign w_sel_addr = (w_sel == PORT_LS) ? ls_addr : if_addr;
    assign w_sel_oor  = (w_sel_addr >= c_DEPTH);

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if_ack   = 1'b0;
        ls_ack   = 1'b0;
        err      = 1'b0;
        case (r_state)
            IDLE: begin
                // Out-of-range accesses skip the memory entirely.
                if (w_valid) begin
                    w_next = w_sel_oor ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                busy     = 1'b1;
                MemRead  = ~r_we;
                MemWrite = r_we;
                if (r_we || (r_cnt == 3'd0)) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                busy   = 1'b1;
                if_ack = (r_owner == PORT_IF);
                ls_ack = (r_owner == PORT_LS);
                err    = r_oor;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch and read-data capture
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_owner      <= PORT_IF;
            r_last_grant <= PORT_LS;
            r_we         <= 1'b0;
            r_oor        <= 1'b0;
            r_cnt        <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner      <= w_sel;
                        r_last_grant <= w_sel;
                        r_addr       <= w_sel_addr;
                        r_we         <= (w_sel == PORT_LS) ? ls_we : 1'b0;
                        r_wdata      <= (w_sel == PORT_LS) ? ls_wdata : '0;
                        r_cnt        <= c_RD_LOAD;
                        r_oor        <= w_sel_oor;
                        // Out-of-range reads return zero alongside the ack.
                        if (w_sel_oor) begin
                            if (w_sel == PORT_IF) r_if_rdata <= '0;
                            else                  r_ls_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (r_we) begin
                        r_ls_rdata <= '0;
                    end else if (r_cnt == 3'd0) begin
                        if (r_owner == PORT_IF) r_if_rdata <= Data_out;
                        else                    r_ls_rdata <= Data_out;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ADDR     = r_addr;
    assign Data_in  = r_wdata;
    assign if_rdata = r_if_rdata;
    assign ls_rdata = r_ls_rdata;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. Two instances
//            share the requester inputs: dut (RD_LAT=1) and dut3 (RD_LAT=3),
//            each with its own 16-word memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        CLK;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [15:0] ls_addr;
    logic [15:0] ls_wdata;

    logic        if_ack, ls_ack, err, busy, MemRead, MemWrite;
    logic [15:0] if_rdata, ls_rdata, ADDR, Data_in, Data_out;

    logic        d3_if_ack, d3_ls_ack, d3_err, d3_busy, d3_MemRead, d3_MemWrite;
    logic [15:0] d3_if_rdata, d3_ls_rdata, d3_ADDR, d3_Data_in, d3_Data_out;

    logic [15:0] mem  [16];
    logic [15:0] mem3 [16];

    int n_cmp;
    int n_err;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(16), .RD_LAT(1)) dut (
        .CLK(CLK), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata), .err(err), .busy(busy),
        .MemRead(MemRead), .MemWrite(MemWrite), .ADDR(ADDR),
        .Data_in(Data_in), .Data_out(Data_out)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(16), .RD_LAT(3)) dut3 (
        .CLK(CLK), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(d3_if_ack), .if_rdata(d3_if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(d3_ls_ack), .ls_rdata(d3_ls_rdata), .err(d3_err), .busy(d3_busy),
        .MemRead(d3_MemRead), .MemWrite(d3_MemWrite), .ADDR(d3_ADDR),
        .Data_in(d3_Data_in), .Data_out(d3_Data_out)
    );

    // Memory models: combinational read, write on the rising edge.
    assign Data_out    = mem[ADDR[3:0]];
    assign d3_Data_out = mem3[d3_ADDR[3:0]];

    always @(posedge CLK) begin
        if (MemWrite)    mem[ADDR[3:0]]     <= Data_in;
        if (d3_MemWrite) mem3[d3_ADDR[3:0]] <= d3_Data_in;
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int acks;
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_addr  = '0;
        ls_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]  = 16'(i * 16'h0101);
            mem3[i] = 16'(i * 16'h0101);
        end
        mem[3]  = 16'h1234;
        mem3[0] = 16'hA5A5;

        // ---- reset state ----
        step(); step();
        chk("rst_busy",    busy, 0);
        chk("rst_strobes", {MemRead, MemWrite}, 0);
        chk("rst_acks",    {if_ack, ls_ack, err}, 0);
        chk("rst_addr",    ADDR, 0);
        chk("rst_din",     Data_in, 0);
        chk("rst_rdata",   {if_rdata, ls_rdata}, 0);
        reset = 1'b0;
        step();

        // ---- single IF read ----
        if_req = 1'b1; if_addr = 16'd3;
        step();
        chk("ifrd_memread", MemRead, 1);
        chk("ifrd_memwr",   MemWrite, 0);
        chk("ifrd_addr",    ADDR, 3);
        chk("ifrd_noack",   if_ack, 0);
        step();
        chk("ifrd_ack",     if_ack, 1);
        chk("ifrd_data",    if_rdata, 16'h1234);
        chk("ifrd_lsack",   ls_ack, 0);
        chk("ifrd_rddrop",  MemRead, 0);
        if_req = 1'b0;
        step();
        chk("ifrd_ackpulse", if_ack, 0);
        chk("ifrd_idle",     busy, 0);
        step(); step(); step();

        // ---- LS write then read-back ----
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'd5; ls_wdata = 16'hBEEF;
        step();
        chk("lswr_memwr",  MemWrite, 1);
        chk("lswr_memrd",  MemRead, 0);
        chk("lswr_addr",   ADDR, 5);
        chk("lswr_din",    Data_in, 16'hBEEF);
        step();
        chk("lswr_ack",    ls_ack, 1);
        chk("lswr_wrdrop", MemWrite, 0);
        ls_we = 1'b0;
        step();
        chk("lsrd_idle",   busy, 0);
        step();
        chk("lsrd_memread", MemRead, 1);
        step();
        chk("lsrd_ack",    ls_ack, 1);
        chk("lsrd_data",   ls_rdata, 16'hBEEF);
        chk("lsrd_err",    err, 0);
        ls_req = 1'b0;
        step(); step(); step(); step();

        // ---- contention from reset: expect IF, LS, IF, LS ----
        reset = 1'b1;
        if_req = 1'b1; if_addr = 16'd3;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'd5;
        step();
        reset = 1'b0;
        acks = 0;
        for (int c = 0; c < 20 && acks < 4; c++) begin
            step();
            chk("cont_overlap", {31'd0, if_ack & ls_ack}, 0);
            if (if_ack || ls_ack) begin
                chk("cont_order", ls_ack, acks % 2);
                chk("cont_data", ls_ack ? ls_rdata : if_rdata,
                    ls_ack ? 16'hBEEF : 16'h1234);
                acks++;
            end
        end
        chk("cont_count", acks, 4);
        if_req = 1'b0; ls_req = 1'b0;
        step(); step(); step(); step(); step(); step();

        // ---- out-of-range LS read ----
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'd16;
        step();
        chk("oor_ack",     ls_ack, 1);
        chk("oor_err",     err, 1);
        chk("oor_rdata",   ls_rdata, 0);
        chk("oor_strobes", {MemRead, MemWrite}, 0);
        ls_req = 1'b0;
        step();
        chk("oor_errpulse", {ls_ack, err}, 0);
        step(); step(); step(); step(); step();

        // ---- RD_LAT=3 instance: IF read of address 0 ----
        chk("lat3_idle", d3_busy, 0);
        if_req = 1'b1; if_addr = 16'd0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("lat3_memread", d3_MemRead, 1);
            chk("lat3_busy",    d3_busy, 1);
            chk("lat3_noack",   d3_if_ack, 0);
            if (c == 0) if_req = 1'b0 | if_req;
        end
        step();
        chk("lat3_rddrop", d3_MemRead, 0);
        chk("lat3_ack",    d3_if_ack, 1);
        chk("lat3_busy4",  d3_busy, 1);
        chk("lat3_data",   d3_if_rdata, 16'hA5A5);
        if_req = 1'b0;
        step();
        chk("lat3_done",   d3_busy, 0);
        step(); step(); step();

        // ---- reset during ACCESS, then first tie goes to IF ----
        if_req = 1'b1; if_addr = 16'd3;
        step();
        chk("rsta_inaccess", MemRead, 1);
        reset = 1'b1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'd5;
        step();
        chk("rsta_memread", MemRead, 0);
        chk("rsta_busy",    busy, 0);
        chk("rsta_noack",   {if_ack, ls_ack}, 0);
        reset = 1'b0;
        step();
        chk("rsta_tie_addr", ADDR, 3);
        chk("rsta_tie_rd",   MemRead, 1);
        step();
        chk("rsta_tie_ifack", if_ack, 1);
        chk("rsta_tie_lsack", ls_ack, 0);
        if_req = 1'b0; ls_req = 1'b0;
        step(); step(); step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
